// File: rtl/ft_pkg.sv
// ft_pkg: shared types and default constants for the write-back alignment stage.
package ft_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_TIMEOUT    = 8;

    typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, PAIR, FAULT} aligner_state_t;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic aligner_state_t occ_state(input logic has_a, input logic has_b);
        return has_a ? (has_b ? PAIR : WAIT_B) : (has_b ? WAIT_A : IDLE);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with wrap-bit pointers, flush and occupancy count.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    localparam logic [PW:0] ONE = 1;

    logic [PW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
        end
    end

    // A push on a full FIFO is only issued alongside a pop, so the slot is free by the edge.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rptr[PW-1:0]];
    assign empty = wptr == rptr;
    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/wb_aligner.sv
// wb_aligner: pairs core A/B register write-backs for the lockstep comparator,
// absorbing bounded skew and flagging timeout or overflow faults.
module wb_aligner
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  we_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic                  we_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  logic                  flush_i,
    output logic                  we_a_o,
    output logic                  we_b_o,
    output logic [ADDR_WIDTH-1:0] addr_a_o,
    output logic [ADDR_WIDTH-1:0] addr_b_o,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  timeout_o,
    output logic                  overflow_o,
    output logic                  fault_o
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    aligner_state_t state, state_next;
    logic [CW-1:0]  count_a, count_b, next_a, next_b;
    logic [EW-1:0]  head_a, head_b;
    logic [SW-1:0]  skew, skew_next;
    logic           full_a, full_b, empty_a, empty_b;
    logic           pop, push_a, push_b, ovf, hit, flt, waiting;

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) fifo_a (
        .clk(clk_i), .rst_n(rst_n), .flush(flush_i), .push(push_a), .pop(pop),
        .din({addr_a_i, data_a_i}), .dout(head_a), .full(full_a), .empty(empty_a), .count(count_a)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) fifo_b (
        .clk(clk_i), .rst_n(rst_n), .flush(flush_i), .push(push_b), .pop(pop),
        .din({addr_b_i, data_b_i}), .dout(head_b), .full(full_b), .empty(empty_b), .count(count_b)
    );

    assign flt     = state == FAULT;
    assign waiting = state == WAIT_A || state == WAIT_B;
    assign pop     = !empty_a && !empty_b && !flt && !flush_i;
    assign push_a  = we_a_i && !flt && !flush_i && (!full_a || pop);
    assign push_b  = we_b_i && !flt && !flush_i && (!full_b || pop);
    assign ovf     = !flt && !flush_i && !pop && ((we_a_i && full_a) || (we_b_i && full_b));
    assign hit     = waiting && !flush_i && skew == SW'(TIMEOUT - 1);
    assign fault_o = flt;

    // Occupancy after this edge, so the registered state tracks the FIFOs it describes.
    always_comb begin
        next_a     = count_a + CW'(push_a) - CW'(pop);
        next_b     = count_b + CW'(push_b) - CW'(pop);
        state_next = flush_i ? IDLE : (flt || hit || ovf) ? FAULT : occ_state(next_a != '0, next_b != '0);
        skew_next  = flush_i ? '0 : waiting ? skew + SW'(1) : flt ? skew : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            skew       <= '0;
            timeout_o  <= 1'b0;
            overflow_o <= 1'b0;
            we_a_o     <= 1'b0;
            we_b_o     <= 1'b0;
            addr_a_o   <= '0;
            addr_b_o   <= '0;
            data_a_o   <= '0;
            data_b_o   <= '0;
        end else begin
            skew       <= skew_next;
            timeout_o  <= hit;
            overflow_o <= !flush_i && (overflow_o || ovf);
            we_a_o     <= pop;
            we_b_o     <= pop;
            addr_a_o   <= pop ? head_a[EW-1:DATA_WIDTH] : '0;
            addr_b_o   <= pop ? head_b[EW-1:DATA_WIDTH] : '0;
            data_a_o   <= pop ? head_a[DATA_WIDTH-1:0] : '0;
            data_b_o   <= pop ? head_b[DATA_WIDTH-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_wb_aligner.sv
// tb_wb_aligner: table-driven checks of pairing, skew, flush and reset,
// plus hand-written timeout, overflow and back-to-back sequences.
module tb_wb_aligner;
    import ft_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, flush_i = 1'b0;
    logic        we_a_i = 1'b0, we_b_i = 1'b0;
    logic [4:0]  addr_a_i = '0, addr_b_i = '0;
    logic [31:0] data_a_i = '0, data_b_i = '0;
    logic        we_a_o, we_b_o, timeout_o, overflow_o, fault_o;
    logic [4:0]  addr_a_o, addr_b_o;
    logic [31:0] data_a_o, data_b_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic           r, f, wa;
        logic [4:0]     aa;
        logic           wb;
        logic [4:0]     ab;
        logic           ew;
        logic [4:0]     ea;
        aligner_state_t st;
    } vec_t;

    vec_t vq[$];

    wb_aligner dut (
        .clk_i(clk), .rst_n(rst_n),
        .we_a_i(we_a_i), .addr_a_i(addr_a_i), .data_a_i(data_a_i),
        .we_b_i(we_b_i), .addr_b_i(addr_b_i), .data_b_i(data_b_i),
        .flush_i(flush_i),
        .we_a_o(we_a_o), .we_b_o(we_b_o),
        .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
        .data_a_o(data_a_o), .data_b_o(data_b_o),
        .timeout_o(timeout_o), .overflow_o(overflow_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] da(input logic [4:0] a);
        return a == 5'd3 ? 32'hDEADBEEF : (32'hA000_0000 | 32'(a));
    endfunction

    function automatic logic [31:0] db(input logic [4:0] a);
        return a == 5'd3 ? 32'hDEADBEEF : (32'hB000_0000 | 32'(a));
    endfunction

    function automatic logic [78:0] outs();
        return {we_a_o, we_b_o, addr_a_o, data_a_o, addr_b_o, data_b_o, timeout_o, overflow_o, fault_o};
    endfunction

    function automatic logic [78:0] expv(input logic ew, input logic [4:0] ea, input logic to, input logic ov, input logic ft);
        return {ew, ew, ew ? ea : 5'd0, ew ? da(ea) : 32'd0, ew ? ea : 5'd0, ew ? db(ea) : 32'd0, to, ov, ft};
    endfunction

    task automatic v(input logic r, f, wa, input logic [4:0] aa, input logic wb, input logic [4:0] ab,
                     input logic ew, input logic [4:0] ea, input aligner_state_t st);
        vq.push_back('{r, f, wa, aa, wb, ab, ew, ea, st});
    endtask

    task automatic step(input logic r, f, wa, input logic [4:0] aa, input logic wb, input logic [4:0] ab);
        @(negedge clk);
        rst_n = r; flush_i = f;
        we_a_i = wa; addr_a_i = aa; data_a_i = da(aa);
        we_b_i = wb; addr_b_i = ab; data_b_i = db(ab);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    initial begin
        // reset and same-cycle pair
        v(0,0,0,0,0,0,0,0,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);
        v(1,0,1,3,1,3,0,0,PAIR);
        v(1,0,0,0,0,0,1,3,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);
        // B leads A by three cycles
        v(1,0,0,0,1,1,0,0,WAIT_A);
        v(1,0,0,0,1,2,0,0,WAIT_A);
        v(1,0,0,0,1,3,0,0,WAIT_A);
        v(1,0,1,1,1,4,0,0,PAIR);
        v(1,0,1,2,0,0,1,1,PAIR);
        v(1,0,1,3,0,0,1,2,PAIR);
        v(1,0,1,4,0,0,1,3,PAIR);
        v(1,0,0,0,0,0,1,4,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);
        // flush beats a pending pop and same-cycle pushes
        v(1,0,1,5,1,5,0,0,PAIR);
        v(1,1,1,6,1,6,0,0,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);
        v(1,0,1,7,1,7,0,0,PAIR);
        v(1,0,0,0,0,0,1,7,IDLE);
        // reset mid-stream
        v(1,0,1,8,1,8,0,0,PAIR);
        v(0,0,1,9,1,9,0,0,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);
        v(1,0,0,0,0,0,0,0,IDLE);

        foreach (vq[i]) begin
            step(vq[i].r, vq[i].f, vq[i].wa, vq[i].aa, vq[i].wb, vq[i].ab);
            chk($sformatf("vec%0d", i), {outs(), dut.state}, {expv(vq[i].ew, vq[i].ea, 1'b0, 1'b0, 1'b0), vq[i].st});
        end

        // timeout: A alone for TIMEOUT cycles
        step(1,0,1,10,0,0);
        chk("to_start", {outs(), dut.state}, {expv(0,0,0,0,0), WAIT_B});
        for (int i = 1; i <= 8; i++) begin
            step(1,0,0,0,0,0);
            chk($sformatf("to_cyc%0d", i), outs(), expv(0, 0, i == 8, 0, i == 8));
        end
        step(1,0,0,0,0,0);
        chk("to_pulse_end", outs(), expv(0,0,0,0,1));
        for (int i = 0; i < 3; i++) begin
            step(1,0,1,5'(11 + i),1,5'(11 + i));
            chk("fault_hold", {outs(), dut.state}, {expv(0,0,0,0,1), FAULT});
        end
        step(1,1,0,0,0,0);
        chk("to_flush", {outs(), dut.state}, {expv(0,0,0,0,0), IDLE});
        step(1,0,1,12,1,12);
        chk("post_flush_push", outs(), expv(0,0,0,0,0));
        step(1,0,0,0,0,0);
        chk("post_flush_pair", outs(), expv(1,12,0,0,0));

        // overflow: five A pushes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            step(1,0,1,5'(16 + i),0,0);
            chk($sformatf("ovf_push%0d", i), outs(), expv(0, 0, 0, i == 5, i == 5));
        end
        step(1,0,0,0,0,0);
        chk("ovf_sticky", outs(), expv(0,0,0,1,1));
        step(1,1,0,0,0,0);
        chk("ovf_flush", {outs(), dut.count_a, dut.count_b, dut.state}, {expv(0,0,0,0,0), 3'd0, 3'd0, IDLE});

        // back-to-back same-cycle writes
        for (int i = 0; i <= 16; i++) begin
            step(1, 0, i < 16, 5'(i), i < 16, 5'(i));
            chk($sformatf("b2b%0d", i), {outs(), dut.count_a <= 3'd1 && dut.count_b <= 3'd1},
                {expv(i > 0, 5'(i - 1), 0, 0, 0), 1'b1});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
